// File: rtl/stable_sampler_pkg.sv
// -----------------------------------------------------------------------------
// stable_sampler_pkg
// Shared defaults and helpers for the stable_sampler front-panel input path.
//   DEF_WIDTH    : default sampled bus width
//   DEF_TICK_DIV : default clocks per sample tick
//   DEF_MATCH_N  : default consecutive equal samples needed for stability
//   cnt_width()  : bits needed to count 0..n-1, never less than 1
// -----------------------------------------------------------------------------
package stable_sampler_pkg;

   localparam int DEF_WIDTH    = 14;
   localparam int DEF_TICK_DIV = 20701;
   localparam int DEF_MATCH_N  = 2;

   // $clog2 returns 0 for n <= 1, which would give a zero-width vector.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running divider that marks one sample instant every TICK_DIV clocks.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-low reset
//   locked    in  synchronous clear, active high
//   sample_en out combinational, high on the clock edge that takes a sample
//   tick      out registered copy of sample_en, high the cycle after that edge
// -----------------------------------------------------------------------------
module tick_gen
   import stable_sampler_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic locked,
   output logic sample_en,
   output logic tick
);

   localparam int                CNT_W    = cnt_width(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // Suppressed while locked so the parent never samples during a clear.
   assign sample_en = !locked && (cnt == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // updates from the same pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (locked) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= sample_en;
         cnt  <= sample_en ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/stable_sampler.sv
// -----------------------------------------------------------------------------
// stable_sampler
// Samples a raw WIDTH-bit switch/keypad bus once per TICK_DIV clocks and
// accepts a value after MATCH_N consecutive equal samples.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-low reset
//   locked     in  synchronous clear, active high (clock source unsettled)
//   num        in  raw input bus, only looked at on a sample edge
//   stable     out high while the last MATCH_N samples were equal
//   stable_val out last accepted stable value
//   update     out one-cycle strobe when stable_val takes a first/new value
//   tick       out one-cycle strobe after each sample instant
// -----------------------------------------------------------------------------
module stable_sampler
   import stable_sampler_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int MATCH_N   = DEF_MATCH_N,
   parameter int HOLD_LAST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             locked,
   input  logic [WIDTH-1:0] num,
   output logic             stable,
   output logic [WIDTH-1:0] stable_val,
   output logic             update,
   output logic             tick
);

   localparam int               RUN_W   = cnt_width(MATCH_N + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MATCH_N);
   // run value that, with one more match, completes a stable streak
   localparam logic [RUN_W-1:0] RUN_ACC = RUN_W'(MATCH_N - 1);

   logic             sample_en;
   logic [WIDTH-1:0] ref_val;
   logic [RUN_W-1:0] run;
   logic             first_done;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk       (clk),
      .rst       (rst),
      .locked    (locked),
      .sample_en (sample_en),
      .tick      (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_val    <= '0;
         run        <= '0;
         stable     <= 1'b0;
         stable_val <= '0;
         update     <= 1'b0;
         first_done <= 1'b0;
      end else if (locked) begin
         ref_val    <= '0;
         run        <= '0;
         stable     <= 1'b0;
         update     <= 1'b0;
         first_done <= 1'b0;
         if (HOLD_LAST == 0) begin
            stable_val <= '0;
         end
      end else begin
         // NOTE: update is defaulted low every cycle so that the single
         // assignment below produces a one-cycle strobe, not a held level.
         update <= 1'b0;
         if (sample_en) begin
            if (num != ref_val) begin
               ref_val <= num;
               run     <= RUN_W'(1);
               stable  <= 1'b0;
            end else begin
               stable <= (run >= RUN_ACC);
               if (run != RUN_MAX) begin
                  run <= run + 1'b1;
               end
               // Acceptance happens only on the transition into a full run,
               // so a long stable period never re-strobes.
               if (run == RUN_ACC) begin
                  stable_val <= ref_val;
                  update     <= !first_done || (ref_val != stable_val);
                  first_done <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_stable_sampler.sv
// -----------------------------------------------------------------------------
// tb_stable_sampler
// Drives two stable_sampler instances (HOLD_LAST=1 and HOLD_LAST=0) from the
// same stimulus and compares them each cycle against a sample-history model.
// -----------------------------------------------------------------------------
module tb_stable_sampler;

   localparam int W  = 14;
   localparam int TD = 4;
   localparam int MN = 3;

   logic          clk;
   logic          rst;
   logic          locked;
   logic [W-1:0]  num;

   logic          stable1, update1, tick1;
   logic [W-1:0]  sval1;
   logic          stable0, update0, tick0;
   logic [W-1:0]  sval0;

   stable_sampler #(
      .WIDTH (W), .TICK_DIV (TD), .MATCH_N (MN), .HOLD_LAST (1)
   ) u_dut_hold (
      .clk (clk), .rst (rst), .locked (locked), .num (num),
      .stable (stable1), .stable_val (sval1), .update (update1), .tick (tick1)
   );

   stable_sampler #(
      .WIDTH (W), .TICK_DIV (TD), .MATCH_N (MN), .HOLD_LAST (0)
   ) u_dut_clr (
      .clk (clk), .rst (rst), .locked (locked), .num (num),
      .stable (stable0), .stable_val (sval0), .update (update0), .tick (tick0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int fails   = 0;

   // ---------------- reference model ----------------
   int           m_k;          // clocks since reset release / locked fall
   logic [W-1:0] m_hist[$];    // most recent samples, at most MN kept
   bit           m_full;       // previous sample completed a full streak
   bit           m_first;      // something has been accepted since clear
   logic [W-1:0] m_sval1;      // expected stable_val, HOLD_LAST=1
   logic [W-1:0] m_sval0;      // expected stable_val, HOLD_LAST=0
   bit           e_tick, e_stable, e_update;

   logic [2*W+5:0] obs, exp_vec;
   assign obs = {tick1, stable1, update1, sval1, tick0, stable0, update0, sval0};
   always_comb exp_vec = {e_tick, e_stable, e_update, m_sval1,
                          e_tick, e_stable, e_update, m_sval0};

   task automatic model_clear(input bit full_reset);
      m_k = 0;
      m_hist.delete();
      m_full   = 1'b0;
      m_first  = 1'b0;
      e_tick   = 1'b0;
      e_stable = 1'b0;
      e_update = 1'b0;
      m_sval0  = '0;
      if (full_reset) m_sval1 = '0;
   endtask

   task automatic model_edge(input bit lk, input logic [W-1:0] n);
      int streak;
      if (lk) begin
         model_clear(1'b0);
         return;
      end
      m_k++;
      e_tick   = (m_k % TD == 0);
      e_update = 1'b0;
      if (e_tick) begin
         m_hist.push_back(n);
         if (m_hist.size() > MN) void'(m_hist.pop_front());
         streak = 0;
         for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] == n) streak++;
            else break;
         end
         e_stable = (streak >= MN);
         if (e_stable && !m_full) begin
            e_update = !m_first || (n != m_sval1);
            m_sval1  = n;
            m_sval0  = n;
            m_first  = 1'b1;
         end
         m_full = e_stable;
      end
   endtask

   // One clock: inputs seen at the rising edge feed the model, outputs are
   // then left to be sampled on the falling edge.
   task automatic step();
      bit           lk = locked;
      logic [W-1:0] n  = num;
      @(posedge clk);
      model_edge(lk, n);
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst    = 1'b0;
      locked = 1'b0;
      num    = '0;
      model_clear(1'b1);
      repeat (2) @(negedge clk);
      vectors++;
      if (obs !== '0) begin
         fails++;
         $display("FAIL reset_state: got %h expected 0", obs);
      end
      rst = 1'b1;
   endtask

   task automatic test_acquire();
      int first_tick = -1, upd_cnt = 0, upd_cyc = -1;
      num = 14'h1234;
      for (int i = 1; i <= 20; i++) begin
         step();
         vectors++;
         if (obs !== exp_vec) begin
            fails++;
            $display("FAIL acquire cyc %0d: got %h expected %h", i, obs, exp_vec);
         end
         if (tick1 && first_tick < 0) first_tick = i;
         if (update1) begin
            upd_cnt++;
            upd_cyc = i;
         end
      end
      vectors++;
      if (first_tick != 4) begin
         fails++;
         $display("FAIL acquire_first_tick: got %0d expected 4", first_tick);
      end
      vectors++;
      if (upd_cnt != 1 || upd_cyc != 12) begin
         fails++;
         $display("FAIL acquire_update: got %0d strobes at %0d expected 1 at 12", upd_cnt, upd_cyc);
      end
      vectors++;
      if (sval1 !== 14'h1234 || stable1 !== 1'b1) begin
         fails++;
         $display("FAIL acquire_value: got %h/%b expected 1234/1", sval1, stable1);
      end
   endtask

   task automatic test_glitch();
      bit glitched = 1'b0;
      int upd_cnt = 0, drift = 0;
      for (int i = 1; i <= 24; i++) begin
         if (((m_k + 1) % TD == 0) && !glitched) begin
            num      = 14'h0001;
            glitched = 1'b1;
         end else begin
            num = 14'h1234;
         end
         step();
         vectors++;
         if (obs !== exp_vec) begin
            fails++;
            $display("FAIL glitch cyc %0d: got %h expected %h", i, obs, exp_vec);
         end
         if (update1 || update0) upd_cnt++;
         if (sval1 !== 14'h1234) drift++;
      end
      vectors++;
      if (upd_cnt != 0 || drift != 0 || stable1 !== 1'b1) begin
         fails++;
         $display("FAIL glitch_reacquire: got upd=%0d drift=%0d stable=%b expected 0/0/1",
                  upd_cnt, drift, stable1);
      end
   endtask

   task automatic test_change();
      int upd_cnt = 0;
      num = 14'h2000;
      for (int i = 1; i <= 16; i++) begin
         step();
         vectors++;
         if (obs !== exp_vec) begin
            fails++;
            $display("FAIL change cyc %0d: got %h expected %h", i, obs, exp_vec);
         end
         if (update1) upd_cnt++;
      end
      vectors++;
      if (upd_cnt != 1 || sval1 !== 14'h2000 || stable1 !== 1'b1) begin
         fails++;
         $display("FAIL change_accept: got upd=%0d val=%h stable=%b expected 1/2000/1",
                  upd_cnt, sval1, stable1);
      end
   endtask

   task automatic test_locked();
      int edges = 0, first_tick = -1, upd_cnt = 0;
      num = 14'h0155;
      for (int i = 0; i < 12 && edges < 2; i++) begin
         step();
         vectors++;
         if (obs !== exp_vec) begin
            fails++;
            $display("FAIL locked_pre cyc %0d: got %h expected %h", i, obs, exp_vec);
         end
         if (e_tick) edges++;
      end
      locked = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         vectors++;
         if (obs !== exp_vec) begin
            fails++;
            $display("FAIL locked_hold cyc %0d: got %h expected %h", i, obs, exp_vec);
         end
      end
      vectors++;
      if (sval1 !== 14'h2000 || sval0 !== '0 || stable1 !== 1'b0 || tick1 !== 1'b0) begin
         fails++;
         $display("FAIL locked_clear: got %h/%h/%b/%b expected 2000/0000/0/0",
                  sval1, sval0, stable1, tick1);
      end
      locked = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         vectors++;
         if (obs !== exp_vec) begin
            fails++;
            $display("FAIL locked_after cyc %0d: got %h expected %h", i, obs, exp_vec);
         end
         if (tick1 && first_tick < 0) first_tick = i;
         if (update1) upd_cnt++;
      end
      vectors++;
      if (first_tick != 4 || upd_cnt != 1 || sval0 !== 14'h0155) begin
         fails++;
         $display("FAIL locked_release: got tick@%0d upd=%0d val0=%h expected 4/1/0155",
                  first_tick, upd_cnt, sval0);
      end
   endtask

   task automatic test_async_reset();
      int first_tick = -1;
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (obs !== '0) begin
         fails++;
         $display("FAIL async_reset: got %h expected 0", obs);
      end
      model_clear(1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      num = 14'h3FFF;
      for (int i = 1; i <= 8; i++) begin
         step();
         vectors++;
         if (obs !== exp_vec) begin
            fails++;
            $display("FAIL async_after cyc %0d: got %h expected %h", i, obs, exp_vec);
         end
         if (tick1 && first_tick < 0) first_tick = i;
      end
      vectors++;
      if (first_tick != 4) begin
         fails++;
         $display("FAIL async_first_tick: got %0d expected 4", first_tick);
      end
   endtask

   task automatic test_off_edge_noise();
      int upd_cnt = 0;
      for (int i = 1; i <= 16; i++) begin
         if ((m_k + 1) % TD == 0) num = 14'h0ABC;
         else                     num = W'($urandom);
         step();
         vectors++;
         if (obs !== exp_vec) begin
            fails++;
            $display("FAIL noise cyc %0d: got %h expected %h", i, obs, exp_vec);
         end
         if (update1) upd_cnt++;
      end
      vectors++;
      if (upd_cnt != 1 || sval1 !== 14'h0ABC || sval0 !== 14'h0ABC) begin
         fails++;
         $display("FAIL noise_accept: got upd=%0d val=%h/%h expected 1/0abc/0abc",
                  upd_cnt, sval1, sval0);
      end
   endtask

   task automatic test_random();
      for (int i = 1; i <= 400; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0:       num = '0;
               1:       num = 14'h1234;
               2:       num = 14'h3FFF;
               default: num = W'($urandom);
            endcase
         end
         locked = ($urandom_range(0, 49) == 0);
         step();
         vectors++;
         if (obs !== exp_vec) begin
            fails++;
            $display("FAIL random cyc %0d: got %h expected %h", i, obs, exp_vec);
         end
      end
      locked = 1'b0;
   endtask

   initial begin
      test_reset();
      test_acquire();
      test_glitch();
      test_change();
      test_locked();
      test_async_reset();
      test_off_edge_noise();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
